// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: 8 lines x 16 bytes in front of a
// 128-bit block memory. Misses run a single read/busywait transaction, then refill.
module icache_controller #(
  parameter int NUM_LINES  = 8,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 10 - 4 - INDEX_BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t                state;
  logic                  waited;
  logic [NUM_LINES-1:0]  valid;
  logic [TAG_BITS-1:0]   tags  [NUM_LINES];
  logic [127:0]          lines [NUM_LINES];

  logic [INDEX_BITS-1:0] index;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   tag;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [127:0]          line;
  logic                  hit;
  logic                  fill;
  logic                  byte_offset_unused;

  assign index      = address[4 +: INDEX_BITS];
  assign tag        = address[4 + INDEX_BITS +: TAG_BITS];
  // mem_address doubles as the latched block number of the outstanding miss.
  assign fill_index = mem_address[INDEX_BITS-1:0];
  assign fill_tag   = mem_address[INDEX_BITS +: TAG_BITS];
  assign line       = lines[index];

  assign hit      = read & valid[index] & (tags[index] == tag);
  assign busywait = read & ~(hit & (state == IDLE));
  // The first MEM_READ cycle is skipped: memory only raises busywait after sampling mem_read.
  assign fill     = (state == MEM_READ) & waited & ~mem_busywait;

  assign byte_offset_unused = ^address[1:0];

  always_comb begin
    instruction = line[31:0];
    case (address[3:2])
      2'd0: instruction = line[31:0];
      2'd1: instruction = line[63:32];
      2'd2: instruction = line[95:64];
      2'd3: instruction = line[127:96];
      default: instruction = line[31:0];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      waited      <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= 6'd0;
      valid       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read && !hit) begin
            mem_address <= address[9:4];
            mem_read    <= 1'b1;
            waited      <= 1'b0;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!waited) begin
            waited <= 1'b1;
          end else if (!mem_busywait) begin
            valid[fill_index] <= 1'b1;
            mem_read          <= 1'b0;
            state             <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

  // Line payload and tags carry no reset; validity alone decides a hit.
  always_ff @(posedge clock) begin
    if (fill && !reset) begin
      lines[fill_index] <= mem_readdata;
      tags[fill_index]  <= fill_tag;
    end
  end

endmodule
